// File: rtl/agc_pkg.sv
// Shared constants, FSM/direction encodings and the 12-bit saturation helper
// used by the AGC gain controller and its datapath.
package agc_pkg;

    localparam int GAIN_FRAC = 5;
    localparam int MID_CODE  = 2048;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_HOLD   = 2'd3
    } agc_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } agc_dir_e;

    function automatic logic signed [11:0] sat12(input logic signed [20:0] v);
        logic signed [11:0] r;
        if (v > 21'sd2047)
            r = 12'sh7FF;
        else if (v < -21'sd2048)
            r = 12'sh800;
        else
            r = v[11:0];
        return r;
    endfunction

endpackage

// File: rtl/agc_gain_apply.sv
// Three-stage gain datapath: recentre the offset-binary sample, multiply by the
// Q3.5 gain latched alongside it, then shift, saturate and restore the offset.
module agc_gain_apply
    import agc_pkg::*;
(
    input  logic        clk_sample,
    input  logic        rst,
    input  logic [11:0] ADin,
    input  logic [7:0]  gain,
    output logic [11:0] DAout
);

    logic signed [12:0] c_d, c_q;
    logic        [7:0]  g_d, g_q;
    logic signed [20:0] p_d, p_q;
    logic        [11:0] da_d, da_q;
    logic signed [20:0] c_ext, g_ext;
    logic signed [11:0] y;

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        c_d   = $signed({1'b0, ADin}) - $signed(13'(MID_CODE));
        g_d   = gain;
        c_ext = $signed({{8{c_q[12]}}, c_q});
        g_ext = $signed({13'b0, g_q});
        p_d   = c_ext * g_ext;
        y     = sat12(p_q >>> GAIN_FRAC);
        da_d  = $unsigned(y) + 12'(MID_CODE);
    end

    // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk_sample) begin
        if (rst) begin
            c_q  <= '0;
            g_q  <= '0;
            p_q  <= '0;
            da_q <= 12'(MID_CODE);
        end else begin
            c_q  <= c_d;
            g_q  <= g_d;
            p_q  <= p_d;
            da_q <= da_d;
        end
    end

    assign DAout = da_q;

endmodule

// File: rtl/agc_gain_ctrl.sv
// AGC loop closer: evaluates each windowed RMS against a target band, steps the
// gain with attack/release/hold rules and drives the gained sample stream.
module agc_gain_ctrl
    import agc_pkg::*;
#(
    parameter int TARGET       = 1024,
    parameter int HYST         = 64,
    parameter int GAIN_INIT    = 32,
    parameter int GAIN_MIN     = 4,
    parameter int GAIN_MAX     = 255,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 1,
    parameter int HOLD_WIN     = 4
) (
    input  logic        clk_sample,
    input  logic        rst,
    input  logic [11:0] ADin,
    input  logic [11:0] RMS,
    input  logic        found,
    output logic [11:0] DAout,
    output logic [7:0]  gain,
    output logic        gain_upd,
    output logic [1:0]  state_dbg
);

    localparam logic [12:0] RMS_HI = 13'(TARGET + HYST);
    localparam logic [12:0] RMS_LO = 13'(TARGET - HYST);

    agc_state_e       state_d, state_q;
    agc_dir_e         dir_d, dir_q;
    logic [11:0]      rms_d, rms_q;
    logic [2:0]       hold_d, hold_q;
    logic [7:0]       gain_d, gain_q;
    logic             upd_d, upd_q;
    logic [12:0]      rms_ext;
    logic signed [9:0] gain_ext, gain_sum;
    logic [7:0]       gain_nxt;

    // Clamp in 10-bit signed so stepping below 0 or above 255 cannot wrap.
    always_comb begin
        gain_ext = $signed({2'b00, gain_q});
        unique case (dir_q)
            DIR_DOWN: gain_sum = gain_ext - 10'(ATTACK_STEP);
            DIR_UP:   gain_sum = gain_ext + 10'(RELEASE_STEP);
            default:  gain_sum = gain_ext;
        endcase
        if (gain_sum < 10'(GAIN_MIN))
            gain_nxt = 8'(GAIN_MIN);
        else if (gain_sum > 10'(GAIN_MAX))
            gain_nxt = 8'(GAIN_MAX);
        else
            gain_nxt = gain_sum[7:0];
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rms_d   = rms_q;
        hold_d  = hold_q;
        gain_d  = gain_q;
        upd_d   = 1'b0;
        rms_ext = {1'b0, rms_q};
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    rms_d   = RMS;
                    state_d = ST_EVAL;
                end
            end
            ST_HOLD: begin
                if (found) begin
                    rms_d   = RMS;
                    hold_d  = (hold_q != 3'd0) ? hold_q - 3'd1 : 3'd0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (rms_ext > RMS_HI)
                    dir_d = DIR_DOWN;
                else if (rms_ext < RMS_LO && hold_q == 3'd0)
                    dir_d = DIR_UP;
                else
                    dir_d = DIR_NONE;
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                gain_d = gain_nxt;
                upd_d  = (gain_nxt != gain_q);
                if (dir_q == DIR_DOWN) begin
                    hold_d  = 3'(HOLD_WIN);
                    state_d = ST_HOLD;
                end else begin
                    state_d = (hold_q != 3'd0) ? ST_HOLD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sample) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_NONE;
            rms_q   <= '0;
            hold_q  <= '0;
            gain_q  <= 8'(GAIN_INIT);
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rms_q   <= rms_d;
            hold_q  <= hold_d;
            gain_q  <= gain_d;
            upd_q   <= upd_d;
        end
    end

    agc_gain_apply u_apply (
        .clk_sample (clk_sample),
        .rst        (rst),
        .ADin       (ADin),
        .gain       (gain_q),
        .DAout      (DAout)
    );

    assign gain      = gain_q;
    assign gain_upd  = upd_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Scoreboard bench for agc_gain_ctrl: stimulus pushes expected gain updates and
// DAout samples with their due cycle; a negedge monitor pops and compares.
module tb_agc_gain_ctrl;

    logic        clk_sample = 1'b0;
    logic        rst;
    logic [11:0] ADin;
    logic [11:0] RMS;
    logic        found;
    logic [11:0] DAout;
    logic [7:0]  gain;
    logic        gain_upd;
    logic [1:0]  state_dbg;

    typedef struct {
        int         cyc;
        logic [7:0] gain;
    } gain_exp_t;

    typedef struct {
        int          cyc;
        logic [11:0] val;
    } da_exp_t;

    gain_exp_t gain_sb[$];
    da_exp_t   da_sb[$];
    int        cyc    = 0;
    int        checks = 0;
    int        errors = 0;

    agc_gain_ctrl dut (
        .clk_sample (clk_sample),
        .rst        (rst),
        .ADin       (ADin),
        .RMS        (RMS),
        .found      (found),
        .DAout      (DAout),
        .gain       (gain),
        .gain_upd   (gain_upd),
        .state_dbg  (state_dbg)
    );

    always #5 clk_sample = ~clk_sample;

    always @(posedge clk_sample) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: gain pulses and DAout samples are compared as the DUT presents them.
    always @(negedge clk_sample) begin
        gain_exp_t ge;
        da_exp_t   de;
        if (gain_upd === 1'b1) begin
            if (gain_sb.size() == 0) begin
                check("gain_upd_unexpected", 32'(gain_upd), 32'd0);
            end else begin
                ge = gain_sb.pop_front();
                check("gain_value", 32'(gain), 32'(ge.gain));
                check("gain_upd_cycle", cyc, ge.cyc);
            end
        end else if (gain_sb.size() != 0 && gain_sb[0].cyc < cyc) begin
            ge = gain_sb.pop_front();
            check("gain_upd_missing", 32'(gain_upd), 32'd1);
        end
        if (da_sb.size() != 0 && da_sb[0].cyc <= cyc) begin
            de = da_sb.pop_front();
            check("DAout", 32'(DAout), 32'(de.val));
        end
    end

    task automatic send_window(input logic [11:0] rms, input int exp_gain);
        @(posedge clk_sample); #1;
        RMS   = rms;
        found = 1'b1;
        if (exp_gain >= 0)
            gain_sb.push_back('{cyc: cyc + 3, gain: 8'(exp_gain)});
        @(posedge clk_sample); #1;
        found = 1'b0;
        RMS   = '0;
        repeat (6) @(posedge clk_sample);
        #1;
    endtask

    task automatic drive_sample(input logic [11:0] vin, input logic [11:0] vexp);
        @(posedge clk_sample); #1;
        ADin = vin;
        da_sb.push_back('{cyc: cyc + 3, val: vexp});
    endtask

    task automatic wait_drain();
        int budget = 30;
        while ((gain_sb.size() != 0 || da_sb.size() != 0) && budget > 0) begin
            @(posedge clk_sample);
            budget--;
        end
        #1;
        check("scoreboard_drained", gain_sb.size() + da_sb.size(), 0);
    endtask

    // Called #1 after a reset edge: DAout must hold mid-code for three cycles.
    task automatic release_reset();
        ADin = 12'h900;
        rst  = 1'b0;
        for (int i = 0; i < 3; i++)
            da_sb.push_back('{cyc: cyc + i, val: 12'h800});
        da_sb.push_back('{cyc: cyc + 3, val: 12'h900});
        wait_drain();
    endtask

    initial begin
        int g;
        rst   = 1'b1;
        ADin  = 12'h900;
        RMS   = '0;
        found = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_sample);
        #1;
        check("reset_gain", 32'(gain), 32'd32);
        check("reset_DAout", 32'(DAout), 32'h800);
        check("reset_gain_upd", 32'(gain_upd), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        release_reset();

        // Unity pass-through, exact 3-cycle latency
        drive_sample(12'h900, 12'h900);
        drive_sample(12'h123, 12'h123);
        drive_sample(12'hABC, 12'hABC);
        drive_sample(12'h800, 12'h800);
        wait_drain();

        // Attack, then hold blocks release for three windows; the fourth releases
        send_window(12'd1500, 28);
        check("state_after_attack", 32'(state_dbg), 32'd3);
        send_window(12'd500, -1);
        send_window(12'd500, -1);
        send_window(12'd500, -1);
        send_window(12'd500, 29);
        check("state_after_hold", 32'(state_dbg), 32'd0);

        // Band edges and a release with the hold expired
        send_window(12'd1024, -1);
        send_window(12'd961, -1);
        send_window(12'd1088, -1);
        send_window(12'd960, -1);
        send_window(12'd900, 30);
        wait_drain();

        // Gain 30: positive, negative and floor-rounding samples
        drive_sample(12'h900, 12'h8F0);
        drive_sample(12'h700, 12'h710);
        drive_sample(12'h801, 12'h800);
        drive_sample(12'h7FF, 12'h7FF);
        wait_drain();

        // Release up to the upper clamp, then once more with no change
        for (g = 31; g <= 255; g++)
            send_window(12'd900, g);
        send_window(12'd900, -1);
        check("gain_at_max", 32'(gain), 32'd255);

        drive_sample(12'hFFF, 12'hFFF);
        drive_sample(12'h000, 12'h000);
        drive_sample(12'h800, 12'h800);
        drive_sample(12'h900, 12'hFF8);
        wait_drain();

        // Attack down to the lower clamp, then hold there silently
        g = 255;
        while (g > 4) begin
            g = (g - 4 < 4) ? 4 : g - 4;
            send_window(12'd4000, g);
        end
        send_window(12'd4000, -1);
        send_window(12'd4000, -1);
        check("gain_at_min", 32'(gain), 32'd4);
        wait_drain();

        // Reset asserted while in UPDATE
        @(posedge clk_sample); #1;
        RMS   = 12'd4000;
        found = 1'b1;
        @(posedge clk_sample); #1;
        found = 1'b0;
        @(posedge clk_sample); #1;
        check("reach_update", 32'(state_dbg), 32'd2);
        rst = 1'b1;
        @(posedge clk_sample); #1;
        check("rst_mid_gain", 32'(gain), 32'd32);
        check("rst_mid_state", 32'(state_dbg), 32'd0);
        check("rst_mid_gain_upd", 32'(gain_upd), 32'd0);
        release_reset();

        // Hold counter cleared by reset: release works immediately
        send_window(12'd900, 33);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
